// File: rtl/wb_uart_pkg.sv
// Shared definitions for the Wishbone-to-UART register bridge: register offsets,
// ERR/IER bit indices, FSM state encoding and the STATUS word helper.
package wb_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_IER    = 2'd2;
  localparam logic [1:0] REG_ERR    = 2'd3;

  localparam int ERR_W           = 2;
  localparam int ERR_TX_OVERRUN  = 0;
  localparam int ERR_RX_UNDERRUN = 1;

  localparam int IER_W        = 3;
  localparam int IER_RX_AVAIL = 0;
  localparam int IER_TX_EMPTY = 1;
  localparam int IER_ERROR    = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  function automatic logic [31:0] status_word(input logic rx_full, input logic rx_empty,
                                              input logic tx_full, input logic tx_empty);
    return {28'b0, rx_full, rx_empty, tx_full, tx_empty};
  endfunction

endpackage

// File: rtl/wb_uart_if.sv
// Wishbone classic slave exposing DATA/STATUS/IER/ERR registers for a UART FIFO pair.
// Optional interrupt output and IER register are enabled by defining WB_UART_IRQ_EN.
module wb_uart_if
  import wb_uart_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wr_uart,
  output logic [7:0]  w_data,
  output logic        rd_uart,
  input  logic [7:0]  rd_data,
  input  logic        tx_full,
  input  logic        tx_empty,
  input  logic        rx_full,
`ifdef WB_UART_IRQ_EN
  output logic        irq,
`endif
  input  logic        rx_empty
);

  state_t           state;
  logic [ERR_W-1:0] err;

  logic             req_p0;
  logic [1:0]       reg_p0;
  logic             wr_dat_p0;
  logic             rd_dat_p0;
  logic             push_p0;
  logic             pop_p0;
  logic [ERR_W-1:0] err_set_p0;
  logic [ERR_W-1:0] err_clr_p0;
  logic [ERR_W-1:0] err_next_p0;
  logic [31:0]      rdata_p0;
  logic [31:0]      ier_word;

  logic unused_bits;
  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i[3:1]};

  // Request decode: a strobe only counts while idle, so a held strobe in ACK is ignored
  assign req_p0    = wb_cyc_i & wb_stb_i & (state == ST_IDLE);
  assign reg_p0    = wb_adr_i[3:2];
  assign wr_dat_p0 = req_p0 &  wb_we_i & (reg_p0 == REG_DATA) & wb_sel_i[0];
  assign rd_dat_p0 = req_p0 & ~wb_we_i & (reg_p0 == REG_DATA);
  assign push_p0   = wr_dat_p0 & ~tx_full;
  assign pop_p0    = rd_dat_p0 & ~rx_empty;

  always_comb begin
    err_set_p0                  = '0;
    err_set_p0[ERR_TX_OVERRUN]  = wr_dat_p0 & tx_full;
    err_set_p0[ERR_RX_UNDERRUN] = rd_dat_p0 & rx_empty;
    err_clr_p0                  = '0;
    if (req_p0 && wb_we_i && (reg_p0 == REG_ERR))
      err_clr_p0 = wb_dat_i[ERR_W-1:0];
    // Set dominates a coincident clear so no error event is ever lost
    err_next_p0 = (err & ~err_clr_p0) | err_set_p0;
  end

  always_comb begin
    rdata_p0 = '0;
    case (reg_p0)
      REG_DATA:   rdata_p0 = rx_empty ? 32'b0 : {24'b0, rd_data};
      REG_STATUS: rdata_p0 = status_word(rx_full, rx_empty, tx_full, tx_empty);
      REG_IER:    rdata_p0 = ier_word;
      REG_ERR:    rdata_p0 = {{(32-ERR_W){1'b0}}, err};
      default:    rdata_p0 = '0;
    endcase
  end

  // Stage boundary: all bus and FIFO strobes are registered into the ACK cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      wr_uart  <= 1'b0;
      rd_uart  <= 1'b0;
      w_data   <= '0;
      err      <= '0;
    end else begin
      err <= err_next_p0;
      case (state)
        ST_IDLE: begin
          if (req_p0) begin
            state    <= ST_ACK;
            wb_ack_o <= 1'b1;
            wr_uart  <= push_p0;
            rd_uart  <= pop_p0;
            wb_dat_o <= wb_we_i ? 32'b0 : rdata_p0;
            if (push_p0)
              w_data <= wb_dat_i[7:0];
          end else begin
            wb_ack_o <= 1'b0;
            wr_uart  <= 1'b0;
            rd_uart  <= 1'b0;
            wb_dat_o <= '0;
          end
        end
        ST_ACK: begin
          state    <= ST_IDLE;
          wb_ack_o <= 1'b0;
          wr_uart  <= 1'b0;
          rd_uart  <= 1'b0;
          wb_dat_o <= '0;
        end
        default: begin
          state    <= ST_IDLE;
          wb_ack_o <= 1'b0;
          wr_uart  <= 1'b0;
          rd_uart  <= 1'b0;
          wb_dat_o <= '0;
        end
      endcase
    end
  end

`ifdef WB_UART_IRQ_EN
  logic [IER_W-1:0] ier;
  logic [IER_W-1:0] irq_src;

  assign ier_word = {{(32-IER_W){1'b0}}, ier};

  always_comb begin
    irq_src               = '0;
    irq_src[IER_RX_AVAIL] = ~rx_empty;
    irq_src[IER_TX_EMPTY] = tx_empty;
    irq_src[IER_ERROR]    = |err;
  end

  // Stage boundary: IER update and registered interrupt (one cycle behind its sources)
  always_ff @(posedge clk) begin
    if (reset) begin
      ier <= '0;
      irq <= 1'b0;
    end else begin
      if (req_p0 && wb_we_i && (reg_p0 == REG_IER) && wb_sel_i[0])
        ier <= wb_dat_i[IER_W-1:0];
      irq <= |(ier & irq_src);
    end
  end
`else
  assign ier_word = '0;
`endif

endmodule
